lsu_bus_ctrl: RTL

Multi-cycle load/store bus controller downstream of the core's LSU. It replaces the single-cycle RAM port (`ram_we`/`ram_addr`/`ram_wdata`). It accepts one memory request at a time from the execute stage and drives a valid/ready data bus with word-aligned address and byte strobes. It returns aligned, sign- or zero-extended load data, or an error for misaligned/illegal accesses and bus timeouts.

---
 rtl/lsu_bus_ctrl.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/lsu_bus_ctrl.sv
// lsu_bus_ctrl: multi-cycle load/store bus controller behind the LSU.
// Accepts one access at a time and drives a valid/ready word bus with byte strobes.
// Returns extended load data, or an error for an illegal/misaligned access or a bus timeout.
module lsu_bus_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_resp_valid,
  input  logic [31:0] bus_rdata,
  input  logic        bus_resp_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // Last counter value before the transaction is abandoned.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state_r, state_s;
  logic [7:0]  cnt_r;
  logic        we_r;
  logic [2:0]  funct3_r;
  logic [1:0]  lane_r;
  logic [31:0] bus_addr_r, bus_wdata_r;
  logic [3:0]  bus_wstrb_r;
  logic [31:0] resp_rdata_r, resp_rdata_s;
  logic        resp_err_r, resp_err_s;
  logic        accept_s;
  logic        timeout_s;

  // Unsupported funct3 for the direction, or an address not aligned to the access size.
  function automatic logic access_bad(input logic we, input logic [2:0] f3, input logic [1:0] a);
    logic bad_f3;
    logic misal;
    if (we) begin
      bad_f3 = f3[2] || (f3[1:0] == 2'b11);
    end else begin
      bad_f3 = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    end
    misal = ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
    return bad_f3 || misal;
  endfunction

  function automatic logic [3:0] strb_of(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return 4'b0011 << a;
      2'b10:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Replicate store data into every lane so the strobes alone pick the bytes.
  function automatic logic [31:0] wdata_of(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] d);
    logic [31:0] sh;
    logic [15:0] half;
    sh   = d >> {a, 3'b000};
    half = a[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{half[15]}}, half};
      3'b010:  return d;
      3'b100:  return {24'd0, sh[7:0]};
      3'b101:  return {16'd0, half};
      default: return 32'd0;
    endcase
  endfunction

  assign timeout_s = (cnt_r == TO_LAST);

  // Next-state logic plus the response word/err to capture on entry to RESP.
  always_comb begin
    state_s      = state_r;
    accept_s     = 1'b0;
    resp_err_s   = 1'b0;
    resp_rdata_s = 32'd0;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          accept_s = 1'b1;
          if (access_bad(req_we, req_funct3, req_addr[1:0])) begin
            state_s    = ST_RESP;
            resp_err_s = 1'b1;
          end else begin
            state_s = ST_REQ;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (timeout_s) begin
          state_s    = ST_RESP;
          resp_err_s = 1'b1;
        end else if (bus_req_ready) begin
          state_s = ST_WAIT;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (bus_resp_valid) begin
          state_s    = ST_RESP;
          resp_err_s = bus_resp_err;
          if (bus_resp_err || we_r) begin
            resp_rdata_s = 32'd0;
          end else begin
            resp_rdata_s = load_ext(funct3_r, lane_r, bus_rdata);
          end
        end else if (timeout_s) begin
          state_s    = ST_RESP;
          resp_err_s = 1'b1;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, timeout counter and registered response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 8'd0;
      resp_rdata_r <= 32'd0;
      resp_err_r   <= 1'b0;
    end else begin
      state_r      <= state_s;
      resp_rdata_r <= resp_rdata_s;
      resp_err_r   <= resp_err_s;
      if (state_r == ST_IDLE) begin
        cnt_r <= 8'd0;
      end else if ((state_r == ST_REQ) || (state_r == ST_WAIT)) begin
        cnt_r <= cnt_r + 8'd1;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Latch the accepted request and its bus-side encoding; held until the next accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_r        <= 1'b0;
      funct3_r    <= 3'd0;
      lane_r      <= 2'd0;
      bus_addr_r  <= 32'd0;
      bus_wdata_r <= 32'd0;
      bus_wstrb_r <= 4'd0;
    end else if (accept_s) begin
      we_r        <= req_we;
      funct3_r    <= req_funct3;
      lane_r      <= req_addr[1:0];
      bus_addr_r  <= {req_addr[31:2], 2'b00};
      bus_wdata_r <= req_we ? wdata_of(req_funct3, req_wdata) : 32'd0;
      bus_wstrb_r <= req_we ? strb_of(req_funct3, req_addr[1:0]) : 4'd0;
    end
  end

  assign req_ready     = (state_r == ST_IDLE);
  assign resp_valid    = (state_r == ST_RESP);
  assign resp_rdata    = resp_rdata_r;
  assign resp_err      = resp_err_r;
  assign bus_req_valid = (state_r == ST_REQ);
  assign bus_we        = we_r;
  assign bus_addr      = bus_addr_r;
  assign bus_wdata     = bus_wdata_r;
  assign bus_wstrb     = bus_wstrb_r;

endmodule
